fpga_row_cfg_loader: RTL and testbench
======================================

Name: fpga_row_cfg_loader

Overview:
Configuration loader that sits directly upstream of the FPGA row tile. It accepts a word-serial bitstream over a valid/ready stream and assembles it in a shadow register. It checks a trailing XOR checksum and, on a match, atomically commits the select buses driven into the row's routing blocks, switch blocks and logic blocks. Active selects never change while a load is in progress or after a failed load.

Parameters:
DATA_W, 8, stream word width in bits; CFG_BITS must be an integer multiple of DATA_W.
CFG_BITS, 632, total configuration bits (180 brb + 432 bsb + 20 lb).
WORDS, CFG_BITS/DATA_W (derived, 79 at defaults), number of data words per frame.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; begins or restarts a frame.
in_valid  in  1  in_data holds a word.
in_data  in  DATA_W  bitstream word.
in_ready  out  1  loader accepts a word this cycle.
busy  out  1  frame in progress (LOAD or CHECK).
done  out  1  sticky; last frame committed.
error  out  1  sticky; last frame failed its checksum.
brbselect  out  180  routing-block selects; cfg_vec[179:0].
bsbselect  out  432  switch-block selects; cfg_vec[611:180].
lbselect  out  20  logic-block selects; cfg_vec[631:612].

Behaviour:
- Clock and reset: clk, single domain. rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, error=0. brbselect, bsbselect and lbselect are all 0 (every switch off). Word counter, shadow register and checksum accumulator are all 0.
- Reset mid-frame aborts the frame and also clears the active selects.
- States:
  - IDLE/DONE/ERR: in_ready=0. start → LOAD. This clears the counter, clears the accumulator, and clears done and error.
  - LOAD: in_ready=1. Each accepted word k (valid&ready, k=0..WORDS-1) is written to shadow[k*DATA_W +: DATA_W], and acc ^= word. After the word k=WORDS-1 is accepted → CHECK.
  - CHECK: in_ready=1. The next accepted word is compared against acc.
    - Equal: shadow is copied to the select outputs on that clock edge (visible the next cycle), done=1, → DONE.
    - Not equal: outputs unchanged, error=1, → ERR.
- busy=1 exactly in LOAD and CHECK.
- Stalls: in_valid=0 holds the state, counter and accumulator with no timeout. in_data is sampled only on handshake.
- start in LOAD or CHECK restarts: counter and acc are cleared, state → LOAD, and any word presented that same cycle is discarded. Active selects are untouched.
- start in IDLE with in_valid=1 in the same cycle: the word is not accepted (in_ready=0).
- Active outputs are registered and change only on a successful commit or on rst. There are no partial updates.
- Counter width is clog2(WORDS+1). The counter never wraps; the transition to CHECK happens at WORDS-1.
- Throughput: one word per cycle. The commit is visible 1 cycle after the checksum handshake.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → all selects 0, in_ready=0, busy=0, done=0, error=0.
- Counting pattern: start, then words k=0..78 (value = k) back-to-back, then checksum 0x4F → in the cycle after the checksum handshake: done=1, busy=0, brbselect[15:0]=0x0100, lbselect=0x4E4D4.
- Bad checksum: load an all-0xFF frame followed by checksum 0x00 (correct value 0xFF) → error=1, done=0, selects keep their prior values. A following good all-0xFF frame with checksum 0xFF → every select bit is 1, done=1, error=0.
- Back-pressure: toggle in_valid randomly (~50%) during the counting-pattern frame → final selects identical to the back-to-back run; busy stays high throughout.
- Restart: after 40 words, pulse start together with in_valid (word 0xAA dropped), then send a full good frame → commit reflects only the new frame; 0xAA does not appear at word 0.
- Reset mid-frame: after a successful commit, start a new frame and assert rst at word 30 → selects return to 0, state IDLE, and no further words are accepted until start.

Source files
------------

// File: rtl/fpga_row_cfg_loader.sv
// rtl/fpga_row_cfg_loader.sv - word-serial configuration loader for one FPGA row tile
// Frames are assembled in a shadow register and committed atomically only when the trailing XOR checksum matches.
module fpga_row_cfg_loader #(
  parameter int DATA_W   = 8,
  parameter int CFG_BITS = 632,
  localparam int WORDS   = CFG_BITS / DATA_W,
  localparam int CW      = $clog2(WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [179:0]      brbselect,
  output logic [431:0]      bsbselect,
  output logic [19:0]       lbselect
);

  localparam int BRB_LO = 0;
  localparam int BSB_LO = 180;
  localparam int LB_LO  = 612;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       count;
  logic [DATA_W-1:0]   acc;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic                accept;
  logic                last_word;
  logic                match;
  logic                load_word;
  logic                commit;
  logic                fail;

  // A start pulse always wins over a word presented in the same cycle.
  assign accept    = in_valid & in_ready & ~start;
  assign last_word = (count == CW'(WORDS - 1));
  assign match     = (in_data == acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    load_word = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (start) begin
          state_nxt = S_LOAD;
        end else if (accept) begin
          load_word = 1'b1;
          if (last_word) begin
            state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (start) begin
          state_nxt = S_LOAD;
        end else if (accept) begin
          if (match) begin
            commit    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            fail      = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      shadow <= '0;
    end else if (start) begin
      count <= '0;
      acc   <= '0;
    end else if (load_word) begin
      shadow[int'(count)*DATA_W +: DATA_W] <= in_data;
      acc   <= acc ^ in_data;
      count <= count + 1'b1;
    end
  end

  // Active selects only move on a verified commit, so a failed or aborted frame leaves the row untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else if (start && !busy) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else if (commit) begin
      active <= shadow;
      done   <= 1'b1;
    end else if (fail) begin
      error <= 1'b1;
    end
  end

  assign brbselect = active[BRB_LO +: 180];
  assign bsbselect = active[BSB_LO +: 432];
  assign lbselect  = active[LB_LO  +: 20];

endmodule

// File: tb/tb_fpga_row_cfg_loader.sv
// tb/tb_fpga_row_cfg_loader.sv - scoreboard bench for fpga_row_cfg_loader
// Expected frame outcomes are queued at issue time and checked when busy falls.
module tb_fpga_row_cfg_loader;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic         error;
  logic [179:0] brbselect;
  logic [431:0] bsbselect;
  logic [19:0]  lbselect;

  typedef struct packed {
    logic         done;
    logic         error;
    logic [631:0] sel;
  } exp_t;

  exp_t         q[$];
  logic [7:0]   frame[79];
  logic [631:0] cur_sel;
  logic [631:0] count_sel;
  logic         prev_busy;
  logic         busy_drop;
  int           total;
  int           bad;

  fpga_row_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .brbselect (brbselect),
    .bsbselect (bsbselect),
    .lbselect  (lbselect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [631:0] act, input logic [631:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [631:0] pack_frame();
    logic [631:0] v;
    v = '0;
    for (int k = 0; k < 79; k++) v[k*8 +: 8] = frame[k];
    return v;
  endfunction

  function automatic logic [7:0] xor_frame();
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 79; k++) x = x ^ frame[k];
    return x;
  endfunction

  always @(negedge clk) begin
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_end", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_done", 632'(done), 632'(e.done));
        chk("mon_error", 632'(error), 632'(e.error));
        chk("mon_brb", 632'(brbselect), 632'(e.sel[179:0]));
        chk("mon_bsb", 632'(bsbselect), 632'(e.sel[611:180]));
        chk("mon_lb", 632'(lbselect), 632'(e.sel[631:612]));
      end
    end
    prev_busy = busy;
  end

  task automatic pulse_start(input logic v, input logic [7:0] d);
    start    = 1'b1;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input bit bp);
    int n;
    if (bp) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        if (busy !== 1'b1) busy_drop = 1'b1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("handshake_timeout", 1, 0);
    if (busy !== 1'b1) busy_drop = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_body(input logic [7:0] ck, input bit bp);
    for (int k = 0; k < 79; k++) send_word(frame[k], bp);
    if (ck == xor_frame()) begin
      cur_sel = pack_frame();
      q.push_back({1'b1, 1'b0, cur_sel});
    end else begin
      q.push_back({1'b0, 1'b1, cur_sel});
    end
    send_word(ck, bp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] ck, input bit bp);
    pulse_start(1'b0, 8'h00);
    run_body(ck, bp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    prev_busy = 1'b0;
    busy_drop = 1'b0;
    cur_sel = '0;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_in_ready", 632'(in_ready), 0);
    chk("rst_busy", 632'(busy), 0);
    chk("rst_done", 632'(done), 0);
    chk("rst_error", 632'(error), 0);
    chk("rst_sel", {lbselect, bsbselect, brbselect}, '0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("idle_no_ready", 632'(in_ready), 0);
    in_valid = 1'b0;

    for (int k = 0; k < 79; k++) frame[k] = 8'(k);
    run_frame(8'h4F, 1'b0);
    count_sel = cur_sel;
    chk("count_brb_lo", 632'(brbselect[15:0]), 632'(16'h0100));
    chk("count_lb", 632'(lbselect), 632'(20'h4E4D4));
    chk("count_busy", 632'(busy), 0);

    for (int k = 0; k < 79; k++) frame[k] = 8'hFF;
    run_frame(8'h00, 1'b0);
    chk("bad_keeps_sel", {lbselect, bsbselect, brbselect}, count_sel);
    run_frame(8'hFF, 1'b0);
    chk("ff_all_ones", 632'(&{lbselect, bsbselect, brbselect}), 1);
    chk("ff_error_clr", 632'(error), 0);

    for (int k = 0; k < 79; k++) frame[k] = 8'(k);
    busy_drop = 1'b0;
    run_frame(8'h4F, 1'b1);
    chk("bp_busy_held", 632'(busy_drop), 0);
    chk("bp_same_sel", {lbselect, bsbselect, brbselect}, count_sel);

    pulse_start(1'b0, 8'h00);
    for (int k = 0; k < 40; k++) send_word(8'hFF, 1'b0);
    pulse_start(1'b1, 8'hAA);
    for (int k = 0; k < 79; k++) frame[k] = 8'(k) ^ 8'h55;
    run_body(8'h1A, 1'b0);
    chk("restart_word0", 632'(brbselect[7:0]), 632'(8'h55));
    chk("restart_done", 632'(done), 1);

    pulse_start(1'b0, 8'h00);
    for (int k = 0; k < 30; k++) send_word(8'h3C, 1'b0);
    cur_sel = '0;
    q.push_back({1'b0, 1'b0, cur_sel});
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_ready", 632'(in_ready), 0);
    chk("midrst_idle", 632'(busy), 0);
    chk("midrst_sel", {lbselect, bsbselect, brbselect}, '0);
    in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 632'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
